// File: rtl/mac_dist_pkg.sv
// Shared definitions for the distance MAC datapath: sequencer states and
// the element/chunk geometry used by mac_dist and its controller.
package mac_dist_pkg;

    localparam int MAC_IN_WIDTH = 16;
    localparam int MAC_CONCAT   = 4;
    localparam int MAC_CHUNK_W  = MAC_CONCAT * MAC_IN_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_dist_ctrl.sv
// Sequencer feeding mac_dist: streams len chunks of two operands from
// synchronous-read memories and captures the final dot product.
module mac_dist_ctrl
    import mac_dist_pkg::*;
#(
    parameter int IN_WIDTH = MAC_IN_WIDTH,
    parameter int CONCAT   = MAC_CONCAT,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    input  logic [ADDR_W-1:0]          base_a,
    input  logic [ADDR_W-1:0]          base_b,
    output logic                       mem_a_en,
    output logic                       mem_b_en,
    output logic [ADDR_W-1:0]          mem_a_addr,
    output logic [ADDR_W-1:0]          mem_b_addr,
    input  logic [CONCAT*IN_WIDTH-1:0] mem_a_data,
    input  logic [CONCAT*IN_WIDTH-1:0] mem_b_data,
    output logic [CONCAT*IN_WIDTH-1:0] mac_in_1,
    output logic [CONCAT*IN_WIDTH-1:0] mac_in_2,
    output logic                       mac_valid,
    output logic                       mac_reset,
    input  logic [2*IN_WIDTH-1:0]      mac_out,
    output logic                       busy,
    output logic                       done,
    output logic [2*IN_WIDTH-1:0]      result
);

    mac_state_e          state_r, state_next;
    logic [LEN_W-1:0]    k_r, k_next;
    logic [LEN_W-1:0]    len_r, len_next;
    logic                en_r, en_next;
    logic [ADDR_W-1:0]   addr_a_r, addr_a_next;
    logic [ADDR_W-1:0]   addr_b_r, addr_b_next;
    logic                first_r, first_next;
    logic                last_r, last_next;
    logic                done_r, done_next;
    logic [2*IN_WIDTH-1:0] result_r, result_next;
    logic                busy_r;
    logic                valid1_r, reset1_r, last1_r, last2_r;

    // Next-state and issue logic; first_r/last_r tag the chunk issued while en_r is high.
    always_comb begin
        state_next  = state_r;
        k_next      = k_r;
        len_next    = len_r;
        en_next     = 1'b0;
        addr_a_next = addr_a_r;
        addr_b_next = addr_b_r;
        first_next  = first_r;
        last_next   = last_r;
        done_next   = 1'b0;
        result_next = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        state_next  = ST_FETCH;
                        len_next    = len;
                        k_next      = {LEN_W{1'b0}};
                        en_next     = 1'b1;
                        addr_a_next = base_a;
                        addr_b_next = base_b;
                        first_next  = 1'b1;
                        last_next   = (len == LEN_W'(1));
                    end else begin
                        done_next   = 1'b1;
                        result_next = {(2*IN_WIDTH){1'b0}};
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_r) begin
                    state_next = ST_DRAIN;
                    en_next    = 1'b0;
                end else begin
                    en_next     = 1'b1;
                    k_next      = k_r + LEN_W'(1);
                    addr_a_next = addr_a_r + ADDR_W'(1);
                    addr_b_next = addr_b_r + ADDR_W'(1);
                    first_next  = 1'b0;
                    last_next   = (k_next == len_r - LEN_W'(1));
                end
            end
            ST_DRAIN: begin
                // mac_out holds the complete sum exactly when the last tag reaches stage 2.
                if (last2_r) begin
                    state_next  = ST_IDLE;
                    done_next   = 1'b1;
                    result_next = mac_out;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            k_r      <= {LEN_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            en_r     <= 1'b0;
            addr_a_r <= {ADDR_W{1'b0}};
            addr_b_r <= {ADDR_W{1'b0}};
            first_r  <= 1'b0;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {(2*IN_WIDTH){1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next;
            k_r      <= k_next;
            len_r    <= len_next;
            en_r     <= en_next;
            addr_a_r <= addr_a_next;
            addr_b_r <= addr_b_next;
            first_r  <= first_next;
            last_r   <= last_next;
            done_r   <= done_next;
            result_r <= result_next;
            busy_r   <= (state_next != ST_IDLE);
        end
    end

    // Tag delay line aligned with the one-cycle memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_r <= 1'b0;
            reset1_r <= 1'b0;
            last1_r  <= 1'b0;
            last2_r  <= 1'b0;
        end else begin
            valid1_r <= en_r;
            reset1_r <= en_r & first_r;
            last1_r  <= en_r & last_r;
            last2_r  <= last1_r;
        end
    end

    assign mem_a_en   = en_r;
    assign mem_b_en   = en_r;
    assign mem_a_addr = addr_a_r;
    assign mem_b_addr = addr_b_r;
    assign mac_in_1   = mem_a_data;
    assign mac_in_2   = mem_b_data;
    assign mac_valid  = valid1_r;
    assign mac_reset  = reset1_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;

endmodule

// File: tb/tb_mac_dist_ctrl.sv
// Directed bench for mac_dist_ctrl with behavioural memories and a
// behavioural mac_dist accumulator.
module tb_mac_dist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  len;
    logic [9:0]  base_a, base_b;
    logic        mem_a_en, mem_b_en;
    logic [9:0]  mem_a_addr, mem_b_addr;
    logic [63:0] mem_a_data = 64'd0;
    logic [63:0] mem_b_data = 64'd0;
    logic [63:0] mac_in_1, mac_in_2;
    logic        mac_valid, mac_reset;
    logic [31:0] mac_acc = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    logic [63:0] mem_a [0:1023];
    logic [63:0] mem_b [0:1023];

    int checks   = 0;
    int failures = 0;

    int          done_cyc, rst_cnt, val_cnt, val_first, en_cnt, busy1;
    logic [9:0]  a1, a2;
    logic [63:0] in1_c2;

    always #5 clk = ~clk;

    mac_dist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b),
        .mem_a_en(mem_a_en), .mem_b_en(mem_b_en),
        .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .mac_in_1(mac_in_1), .mac_in_2(mac_in_2),
        .mac_valid(mac_valid), .mac_reset(mac_reset),
        .mac_out(mac_acc), .busy(busy), .done(done), .result(result)
    );

    function automatic logic [31:0] dot(input logic [63:0] a, input logic [63:0] b);
        logic [31:0] s;
        logic signed [15:0] x, y;
        logic signed [31:0] p;
        s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            x = a[i*16 +: 16];
            y = b[i*16 +: 16];
            p = x * y;
            s = s + p;
        end
        return s;
    endfunction

    function automatic logic [63:0] pk(input logic [15:0] e0, input logic [15:0] e1,
                                       input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    always @(posedge clk) begin
        if (mem_a_en) mem_a_data <= mem_a[mem_a_addr];
        if (mem_b_en) mem_b_data <= mem_b[mem_b_addr];
    end

    always @(posedge clk) begin
        if (rst) mac_acc <= 32'd0;
        else if (mac_valid) mac_acc <= (mac_reset ? 32'd0 : mac_acc) + dot(mac_in_1, mac_in_2);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command (start in cycle 0) and samples cycles 1.. until done or timeout.
    task automatic run_cmd(input logic [9:0] n, input logic [9:0] ba, input logic [9:0] bb,
                           input logic [31:0] exp_res, input string tag,
                           input bit b2b, input bit poke);
        if (!b2b) @(negedge clk);
        start = 1'b1; len = n; base_a = ba; base_b = bb;
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0; rst_cnt = 0; val_cnt = 0; val_first = 0; en_cnt = 0; busy1 = 0;
        for (int c = 1; c <= int'(n) + 10 && done_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin busy1 = int'(busy); a1 = mem_a_addr; end
            if (c == 2) begin a2 = mem_a_addr; in1_c2 = mac_in_1; end
            if (poke && c == 2) begin start = 1'b1; len = 10'd1; base_a = 10'd0; base_b = 10'd0; end
            if (poke && c == 3) start = 1'b0;
            if (mem_a_en && mem_b_en) en_cnt++;
            if (mac_reset) rst_cnt++;
            if (mac_valid) begin
                val_cnt++;
                if (val_first == 0) val_first = c;
            end
            if (done) begin
                done_cyc = c;
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(int'(n) + ((n == 10'd0) ? 1 : 3)));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_reset_cnt"}, 64'(rst_cnt), (n == 10'd0) ? 64'd0 : 64'd1);
        check({tag, "_valid_cnt"}, 64'(val_cnt), 64'(n));
        check({tag, "_en_cnt"}, 64'(en_cnt), 64'(n));
        check({tag, "_busy_c1"}, 64'(busy1), (n == 10'd0) ? 64'd0 : 64'd1);
        if (n != 10'd0) check({tag, "_valid_first"}, 64'(val_first), 64'd2);
    endtask

    initial begin
        int dcount;
        for (int i = 0; i < 1024; i++) begin mem_a[i] = 64'd0; mem_b[i] = 64'd0; end
        mem_a[0] = pk(16'd1, 16'd2, 16'd3, 16'd4);
        mem_b[0] = pk(16'd5, 16'd6, 16'd7, 16'd8);
        for (int i = 10; i < 13; i++) mem_a[i] = pk(16'd2, 16'd2, 16'd2, 16'd2);
        for (int i = 40; i < 43; i++) mem_b[i] = pk(16'd3, 16'd3, 16'd3, 16'd3);
        mem_a[50] = pk(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        mem_b[50] = pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int i = 60; i < 62; i++) begin
            mem_a[i] = pk(16'd0, 16'd0, 16'd0, 16'h8000);
            mem_b[i] = pk(16'd0, 16'd0, 16'd0, 16'h8000);
        end
        mem_a[20] = pk(16'd1, 16'd1, 16'd1, 16'd1);
        mem_b[20] = pk(16'd1, 16'd1, 16'd1, 16'd1);
        mem_a[1023] = pk(16'd1, 16'd1, 16'd1, 16'd1);
        mem_b[1023] = pk(16'd2, 16'd2, 16'd2, 16'd2);

        rst = 1'b1; start = 1'b0; len = 10'd0; base_a = 10'd0; base_b = 10'd0;
        repeat (2) @(negedge clk);
        check("rst_en", 64'(mem_a_en), 64'd0);
        check("rst_addr", 64'(mem_a_addr), 64'd0);
        check("rst_valid", 64'(mac_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst = 1'b0;

        run_cmd(10'd1, 10'd0, 10'd0, 32'd70, "t1", 1'b0, 1'b0);
        check("t1_mac_in_1", in1_c2, pk(16'd1, 16'd2, 16'd3, 16'd4));

        run_cmd(10'd3, 10'd10, 10'd40, 32'd72, "t2", 1'b0, 1'b1);
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("t2_ignored_start", 64'(dcount), 64'd0);

        run_cmd(10'd1, 10'd50, 10'd50, 32'd131072, "sgn1", 1'b0, 1'b0);
        run_cmd(10'd2, 10'd60, 10'd60, 32'h8000_0000, "sgn2", 1'b0, 1'b0);

        run_cmd(10'd1, 10'd0, 10'd0, 32'd70, "b2b_a", 1'b0, 1'b0);
        run_cmd(10'd1, 10'd20, 10'd20, 32'd4, "b2b_b", 1'b1, 1'b0);

        run_cmd(10'd0, 10'd5, 10'd5, 32'd0, "len0", 1'b0, 1'b0);

        run_cmd(10'd2, 10'd1023, 10'd1023, 32'd78, "wrap", 1'b0, 1'b0);
        check("wrap_addr0", 64'(a1), 64'd1023);
        check("wrap_addr1", 64'(a2), 64'd0);

        // Reset asserted during cycle 3 of a len=5 command.
        @(negedge clk);
        start = 1'b1; len = 10'd5; base_a = 10'd30; base_b = 10'd30;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_en", 64'(mem_a_en), 64'd0);
        check("mrst_valid", 64'(mac_valid), 64'd0);
        check("mrst_mac_reset", 64'(mac_reset), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_result", 64'(result), 64'd0);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || mac_valid) dcount++;
        end
        check("mrst_quiet", 64'(dcount), 64'd0);
        run_cmd(10'd1, 10'd0, 10'd0, 32'd70, "post_rst", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
